// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM and the
// ALU-control decoder that consumes alu_op.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_FAULT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and therefore run the timer.
  function automatic logic is_mem_wait(input state_e s);
    logic r;
    case (s)
      S_FETCH, S_MEMRD, S_MEMWR: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive memory-wait counter; flags a timeout on the last tolerated
// wait cycle so the FSM can divert to FAULT at the next edge.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 32'd1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating increment so a disabled timeout never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = TO_EN && count_en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback and decodes every datapath strobe/select.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] fault,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [1:0] fault_q, fault_d;
  logic       timeout_s;
  logic       wait_en_s;
  logic       wait_clr_s;

  assign wait_en_s  = is_mem_wait(state_q) && !mem_ready;
  assign wait_clr_s = mem_ready || (state_d != state_q);

  mc_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en_i (wait_en_s),
    .clear_i    (wait_clr_s),
    .timeout_o  (timeout_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // FAULT is absorbing, so fault_q is only ever written on entry and the first cause sticks.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (state_q == S_MEMRD) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (timeout_s) begin
          state_d = S_FAULT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          state_d = state_q;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d = S_FAULT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FAULT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default: begin
        state_d = S_FAULT;
        fault_d = FAULT_ILLEGAL;
      end
    endcase
  end

  // Moore decode; only the FETCH PC/IR loads follow mem_ready directly.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: an instruction-level planner expands each instruction
// into the expected per-cycle state trace, and a per-state table gives outputs.
module tb_multicycle_control;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source, fault;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic [1:0] flt;
    logic [5:0] op;
  } step_t;

  step_t      plan_q[$];
  logic [1:0] m_fault = 2'b00;
  logic [5:0] m_op    = 6'h00;

  multicycle_control #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, mtr, rd, rw, sa;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mr, mw, irw, mtr, rd, rw, sa} = 10'b0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1'b1; sb = 2'b01; pw = rdy; irw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  begin iod = 1'b1; mr = 1'b1; end
      4'd4:  begin rw = 1'b1; mtr = 1'b1; end
      4'd5:  begin iod = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
      4'd9:  begin pw = 1'b1; ps = 2'b10; end
      4'd10: begin sa = 1'b1; sb = 2'b10; end
      4'd11: rw = 1'b1;
      default: pw = 1'b0;
    endcase
    return {pw, pwc, iod, mr, mw, irw, mtr, rd, rw, sa, sb, ao, ps};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st = st; s.rdy = rdy; s.flt = m_fault; s.op = m_op;
    plan_q.push_back(s);
  endtask

  task automatic hold_fault(input int n);
    for (int i = 0; i < n; i++) push(4'd15, 1'($urandom_range(0, 1)));
  endtask

  // A memory step with 'waits' not-ready cycles; T consecutive waits time out.
  task automatic mem_phase(input logic [3:0] st, input int waits, output bit faulted);
    if (waits >= T) begin
      for (int i = 0; i < T; i++) push(st, 1'b0);
      m_fault = 2'b10;
      hold_fault(3);
      faulted = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) push(st, 1'b0);
      push(st, 1'b1);
      faulted = 1'b0;
    end
  endtask

  task automatic plan_instr(input logic [5:0] op, input int wf, input int wm, input int fault_hold);
    bit f;
    m_op = op;
    mem_phase(4'd0, wf, f);
    if (f) return;
    push(4'd1, 1'($urandom_range(0, 1)));
    case (op)
      6'h23: begin
        push(4'd2, 1'($urandom_range(0, 1)));
        mem_phase(4'd3, wm, f);
        if (!f) push(4'd4, 1'($urandom_range(0, 1)));
      end
      6'h2B: begin
        push(4'd2, 1'($urandom_range(0, 1)));
        mem_phase(4'd5, wm, f);
      end
      6'h00: begin push(4'd6, 1'b1); push(4'd7, 1'b0); end
      6'h04: push(4'd8, 1'b1);
      6'h02: push(4'd9, 1'b0);
      6'h08: begin push(4'd10, 1'b0); push(4'd11, 1'b1); end
      default: begin
        m_fault = 2'b01;
        hold_fault(fault_hold);
      end
    endcase
  endtask

  task automatic run_plan(input int max_steps);
    step_t s;
    int n = 0;
    while (plan_q.size() > 0 && n < max_steps) begin
      s = plan_q.pop_front();
      opcode    = s.op;
      mem_ready = s.rdy;
      #1;
      check($sformatf("state@exp%0d", s.st), {12'b0, state}, {12'b0, s.st});
      check($sformatf("fault@st%0d", s.st), {14'b0, fault}, {14'b0, s.flt});
      check($sformatf("outs@st%0d", s.st),
            {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source},
            exp_outs(s.st, s.rdy));
      @(negedge clk);
      n++;
    end
    plan_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", {12'b0, state}, 16'd0);
    check("reset_fault", {14'b0, fault}, 16'd0);
    check("reset_outs",
          {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source},
          exp_outs(4'd0, 1'b1));
    rst_n   = 1'b1;
    m_fault = 2'b00;
  endtask

  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

  initial begin
    logic [5:0] op;
    int wf, wm;
    opcode = 6'h00;
    do_reset();

    // Directed instruction mix, all memory ready or short waits.
    plan_instr(6'h00, 0, 0, 0);
    plan_instr(6'h23, 0, 3, 0);
    plan_instr(6'h04, 0, 0, 0);
    plan_instr(6'h02, 0, 0, 0);
    plan_instr(6'h08, 0, 0, 0);
    plan_instr(6'h2B, 0, 2, 0);
    plan_instr(6'h00, 3, 0, 0);
    run_plan(1000);

    // Illegal opcode holds FAULT for 10 cycles, then reset clears it.
    plan_instr(6'h3F, 0, 0, 10);
    run_plan(1000);
    do_reset();

    // Timeouts in FETCH, MEMRD and MEMWR.
    plan_instr(6'h00, 4, 0, 0);
    run_plan(1000);
    do_reset();
    plan_instr(6'h23, 1, 4, 0);
    run_plan(1000);
    do_reset();
    plan_instr(6'h2B, 0, 4, 0);
    run_plan(1000);
    do_reset();

    // Reset in the middle of a memory read.
    plan_instr(6'h23, 0, 3, 0);
    run_plan(4);
    do_reset();

    // Randomized instruction stream with occasional faults and mid-flight resets.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      wf = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, T - 1));
      wm = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, T - 1));
      plan_instr(op, wf, wm, 2);
      if ($urandom_range(0, 9) == 0) begin
        run_plan(int'($urandom_range(1, 5)));
        do_reset();
      end else begin
        run_plan(1000);
        if (m_fault != 2'b00) do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
